// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite row fetch path: FSM state, sprite
// slot numbering and the tag carried alongside each ROM read.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    localparam int unsigned SPRITE_PACMAN = 0;
    localparam int unsigned SPRITE_RED    = 1;
    localparam int unsigned SPRITE_GREEN  = 2;
    localparam int unsigned SPRITE_BLUE   = 3;

    localparam int unsigned SCREEN_LINES  = 480;
    localparam int unsigned Y_W           = 10;

    // Slot index width covers pac-man plus the three ghosts.
    localparam int unsigned TAG_IDX_W     = 2;

    typedef struct packed {
        logic [TAG_IDX_W-1:0] idx;
        logic                 hit;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

    // Row of a sprite needed on a line; a line above the sprite wraps large.
    function automatic logic [Y_W-1:0] row_offset(input logic [Y_W-1:0] line,
                                                  input logic [Y_W-1:0] top);
        return Y_W'(line - top);
    endfunction

endpackage

// File: rtl/sprite_row_fetcher_tag_pipe.sv
// Delay line that carries each issue slot's tag alongside its ROM read so the
// tag pops out in the same cycle the ROM data becomes valid.
module sprite_tag_pipe
    import sprite_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    output logic [TAG_W-1:0] out_tag
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];

    always_comb begin : shift
        vld_d[0] = in_vld;
        tag_d[0] = in_tag;
        for (int i = 1; i < int'(DEPTH); i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    // Reset flushes everything so returns for abandoned reads are dropped.
    always_ff @(posedge Clk) begin : regs
        if (Reset) begin
            vld_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/sprite_row_fetcher.sv
// Per-scanline sprite row fetcher: during hblank reads each visible sprite's
// next-line row from the shared pattern ROM into a back bank, published on swap.
module sprite_row_fetcher
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPRITE_W    = 16,
    parameter int unsigned SPRITE_H    = 16,
    parameter int unsigned PIX_BITS    = 4,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned ROM_LAT     = 2
) (
    input  logic                                   Clk,
    input  logic                                   Reset,
    input  logic                                   line_start,
    input  logic [9:0]                             next_line,
    input  logic                                   swap,
    input  logic [NUM_SPRITES-1:0]                 sprite_en,
    input  logic [NUM_SPRITES*10-1:0]              sprite_y,
    input  logic [NUM_SPRITES*ADDR_W-1:0]          sprite_base,
    output logic                                   rom_rd_en,
    output logic [ADDR_W-1:0]                      rom_addr,
    input  logic [SPRITE_W*PIX_BITS-1:0]           rom_rdata,
    output logic [NUM_SPRITES*SPRITE_W*PIX_BITS-1:0] row_data,
    output logic [NUM_SPRITES-1:0]                 row_valid,
    output logic                                   busy,
    output logic                                   fetch_done,
    output logic                                   err_overrun,
    output logic                                   err_late,
    input  logic                                   err_clr
);

    localparam int unsigned ROW_W = SPRITE_W * PIX_BITS;
    localparam int unsigned BANK_W = NUM_SPRITES * ROW_W;
    localparam int unsigned IDX_W = TAG_IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    fetch_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [Y_W-1:0]                snap_line_q, snap_line_d;
    logic [NUM_SPRITES-1:0]        snap_en_q, snap_en_d;
    logic [NUM_SPRITES*Y_W-1:0]    snap_y_q, snap_y_d;
    logic [NUM_SPRITES*ADDR_W-1:0] snap_base_q, snap_base_d;

    logic              rom_rd_en_q, rom_rd_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              busy_q, busy_d;
    logic              fetch_done_q, fetch_done_d;
    logic              err_overrun_q, err_overrun_d;
    logic              err_late_q, err_late_d;

    logic [BANK_W-1:0]      back_data_q, back_data_d;
    logic [NUM_SPRITES-1:0] back_valid_q, back_valid_d;
    logic [BANK_W-1:0]      front_data_q, front_data_d;
    logic [NUM_SPRITES-1:0] front_valid_q, front_valid_d;

    tag_t             issue_tag;
    logic             issue_vld;
    logic             ret_vld;
    logic [TAG_W-1:0] ret_raw;
    tag_t             ret_tag;

    logic              issue_next;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_en;
    logic [Y_W-1:0]    sel_y;
    logic [Y_W-1:0]    sel_line;
    logic [ADDR_W-1:0] sel_base;
    logic [Y_W-1:0]    dy;
    logic              hit;

    // The registered read strobe doubles as the hit flag of the slot in flight.
    assign issue_vld = (state_q == ISSUE);
    assign issue_tag = '{idx: idx_q, hit: rom_rd_en_q};

    sprite_tag_pipe #(
        .DEPTH (ROM_LAT)
    ) u_tag_pipe (
        .Clk     (Clk),
        .Reset   (Reset),
        .in_vld  (issue_vld),
        .in_tag  (issue_tag),
        .out_vld (ret_vld),
        .out_tag (ret_raw)
    );

    assign ret_tag = tag_t'(ret_raw);

    always_comb begin : next_state
        state_d       = state_q;
        idx_d         = idx_q;
        snap_line_d   = snap_line_q;
        snap_en_d     = snap_en_q;
        snap_y_d      = snap_y_q;
        snap_base_d   = snap_base_q;
        rom_rd_en_d   = 1'b0;
        rom_addr_d    = rom_addr_q;
        busy_d        = busy_q;
        fetch_done_d  = 1'b0;
        err_overrun_d = err_overrun_q;
        err_late_d    = err_late_q;
        back_data_d   = back_data_q;
        back_valid_d  = back_valid_q;
        front_data_d  = front_data_q;
        front_valid_d = front_valid_q;
        issue_next    = 1'b0;
        sel_idx       = '0;
        sel_en        = 1'b0;
        sel_y         = '0;
        sel_line      = '0;
        sel_base      = '0;

        // Select the slot whose read goes out on the next cycle.
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (line_start) begin
                    state_d      = ISSUE;
                    idx_d        = '0;
                    busy_d       = 1'b1;
                    snap_line_d  = next_line;
                    snap_en_d    = sprite_en;
                    snap_y_d     = sprite_y;
                    snap_base_d  = sprite_base;
                    back_valid_d = '0;
                    issue_next   = 1'b1;
                    sel_line     = next_line;
                    sel_en       = sprite_en[0];
                    sel_y        = sprite_y[0 +: Y_W];
                    sel_base     = sprite_base[0 +: ADDR_W];
                end
            end
            ISSUE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    sel_idx    = idx_q + 1'b1;
                    idx_d      = sel_idx;
                    issue_next = 1'b1;
                    sel_line   = snap_line_q;
                    sel_en     = snap_en_q[sel_idx];
                    sel_y      = snap_y_q[int'(sel_idx) * Y_W +: Y_W];
                    sel_base   = snap_base_q[int'(sel_idx) * ADDR_W +: ADDR_W];
                end
            end
            DRAIN: begin
                if (ret_vld && (ret_tag.idx == LAST_IDX)) begin
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    fetch_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        dy  = row_offset(sel_line, sel_y);
        hit = sel_en && (dy < Y_W'(SPRITE_H));
        if (issue_next) begin
            rom_rd_en_d = hit;
            if (hit) begin
                rom_addr_d = ADDR_W'(sel_base + ADDR_W'(dy));
            end
        end

        if (ret_vld && ret_tag.hit) begin
            back_data_d[int'(ret_tag.idx) * ROW_W +: ROW_W] = rom_rdata;
            back_valid_d[ret_tag.idx]                       = 1'b1;
        end

        // A late swap blanks the front rather than expose a half-built bank.
        if (swap) begin
            if (busy_q) begin
                front_valid_d = '0;
            end else begin
                front_data_d  = back_data_q;
                front_valid_d = back_valid_q;
            end
        end

        if (err_clr) begin
            err_overrun_d = 1'b0;
            err_late_d    = 1'b0;
        end
        if (line_start && busy_q) begin
            err_overrun_d = 1'b1;
        end
        if (swap && busy_q) begin
            err_late_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin : regs
        if (Reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            snap_line_q   <= '0;
            snap_en_q     <= '0;
            snap_y_q      <= '0;
            snap_base_q   <= '0;
            rom_rd_en_q   <= 1'b0;
            rom_addr_q    <= '0;
            busy_q        <= 1'b0;
            fetch_done_q  <= 1'b0;
            err_overrun_q <= 1'b0;
            err_late_q    <= 1'b0;
            back_data_q   <= '0;
            back_valid_q  <= '0;
            front_data_q  <= '0;
            front_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_line_q   <= snap_line_d;
            snap_en_q     <= snap_en_d;
            snap_y_q      <= snap_y_d;
            snap_base_q   <= snap_base_d;
            rom_rd_en_q   <= rom_rd_en_d;
            rom_addr_q    <= rom_addr_d;
            busy_q        <= busy_d;
            fetch_done_q  <= fetch_done_d;
            err_overrun_q <= err_overrun_d;
            err_late_q    <= err_late_d;
            back_data_q   <= back_data_d;
            back_valid_q  <= back_valid_d;
            front_data_q  <= front_data_d;
            front_valid_q <= front_valid_d;
        end
    end

    assign rom_rd_en   = rom_rd_en_q;
    assign rom_addr    = rom_addr_q;
    assign row_data    = front_data_q;
    assign row_valid   = front_valid_q;
    assign busy        = busy_q;
    assign fetch_done  = fetch_done_q;
    assign err_overrun = err_overrun_q;
    assign err_late    = err_late_q;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher with a two-cycle ROM model whose word
// content is derived from the address.
module tb_sprite_row_fetcher;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned RW = 64;

    logic            clk;
    logic            reset;
    logic            line_start;
    logic [9:0]      next_line;
    logic            swap;
    logic [NS-1:0]   sprite_en;
    logic [NS*10-1:0] sprite_y;
    logic [NS*AW-1:0] sprite_base;
    logic            rom_rd_en;
    logic [AW-1:0]   rom_addr;
    logic [RW-1:0]   rom_rdata;
    logic [NS*RW-1:0] row_data;
    logic [NS-1:0]   row_valid;
    logic            busy;
    logic            fetch_done;
    logic            err_overrun;
    logic            err_late;
    logic            err_clr;

    int checks;
    int errors;

    logic [RW-1:0] rom_p1;

    sprite_row_fetcher #(
        .NUM_SPRITES (4),
        .SPRITE_W    (16),
        .SPRITE_H    (16),
        .PIX_BITS    (4),
        .ADDR_W      (10),
        .ROM_LAT     (2)
    ) dut (
        .Clk         (clk),
        .Reset       (reset),
        .line_start  (line_start),
        .next_line   (next_line),
        .swap        (swap),
        .sprite_en   (sprite_en),
        .sprite_y    (sprite_y),
        .sprite_base (sprite_base),
        .rom_rd_en   (rom_rd_en),
        .rom_addr    (rom_addr),
        .rom_rdata   (rom_rdata),
        .row_data    (row_data),
        .row_valid   (row_valid),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .err_overrun (err_overrun),
        .err_late    (err_late),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] rom_word(input logic [9:0] a);
        return {a, 6'h2A, ~a, 6'h15, a, 6'h33, 16'hBEEF};
    endfunction

    // ROM model: data valid two cycles after the strobe, junk otherwise.
    always @(posedge clk) begin
        rom_p1    <= rom_rd_en ? rom_word(rom_addr) : 64'hDEAD_DEAD_DEAD_DEAD;
        rom_rdata <= rom_p1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic [3:0] en,
                       input logic [9:0] y0, input logic [9:0] y1,
                       input logic [9:0] y2, input logic [9:0] y3,
                       input logic [9:0] b0, input logic [9:0] b1,
                       input logic [9:0] b2, input logic [9:0] b3);
        sprite_en   = en;
        sprite_y    = {y3, y2, y1, y0};
        sprite_base = {b3, b2, b1, b0};
    endtask

    // Pulses line_start in the current cycle (cycle 0); returns in cycle 1.
    task automatic start_line(input logic [9:0] nl);
        next_line  = nl;
        line_start = 1'b1;
        step(1);
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int at);
        at = from;
        while (fetch_done !== 1'b1 && at < 40) begin
            step(1);
            at++;
        end
    endtask

    task automatic swap_now();
        swap = 1'b1;
        step(1);
        swap = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        checks++;
        if ({busy, rom_rd_en, fetch_done, err_overrun, err_late} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 00000",
                     {busy, rom_rd_en, fetch_done, err_overrun, err_late});
        end
        checks++;
        if (row_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_row_valid: got %b exp 0000", row_valid);
        end
        checks++;
        if (row_data !== '0) begin
            errors++;
            $display("FAIL reset_row_data: got %h exp 0", row_data);
        end
        checks++;
        if (rom_addr !== 10'h000) begin
            errors++;
            $display("FAIL reset_rom_addr: got %h exp 000", rom_addr);
        end
    endtask

    task automatic test_single_hit();
        logic [2:0] exp_flags;
        cfg(4'b0001, 10'd100, 10'd300, 10'd300, 10'd300,
            10'h040, 10'h100, 10'h200, 10'h300);
        start_line(10'd105);
        for (int c = 1; c <= 7; c++) begin
            exp_flags = {1'(c == 1), 1'(c <= 6), 1'(c == 7)};
            checks++;
            if ({rom_rd_en, busy, fetch_done} !== exp_flags) begin
                errors++;
                $display("FAIL single_timing c%0d: rd/busy/done got %b exp %b",
                         c, {rom_rd_en, busy, fetch_done}, exp_flags);
            end
            if (c == 1 || c == 4) begin
                checks++;
                if (rom_addr !== 10'h045) begin
                    errors++;
                    $display("FAIL single_addr c%0d: got %h exp 045", c, rom_addr);
                end
            end
            if (c < 7) step(1);
        end
        swap_now();
        checks++;
        if (row_valid !== 4'b0001) begin
            errors++;
            $display("FAIL single_valid: got %b exp 0001", row_valid);
        end
        checks++;
        if (row_data[RW-1:0] !== rom_word(10'h045)) begin
            errors++;
            $display("FAIL single_data: got %h exp %h", row_data[RW-1:0], rom_word(10'h045));
        end
    endtask

    task automatic test_boundaries();
        int lines [4] = '{99, 100, 115, 116};
        int exp_v [4] = '{0, 1, 1, 0};
        int exp_a [4] = '{0, 'h040, 'h04F, 0};
        int at;
        for (int i = 0; i < 4; i++) begin
            cfg(4'b0001, 10'd100, 10'd300, 10'd300, 10'd300,
                10'h040, 10'h100, 10'h200, 10'h300);
            start_line(10'(lines[i]));
            wait_done(1, at);
            swap_now();
            checks++;
            if (row_valid !== {3'b000, 1'(exp_v[i])}) begin
                errors++;
                $display("FAIL boundary_valid line%0d: got %b exp %0d",
                         lines[i], row_valid, exp_v[i]);
            end
            if (exp_v[i] == 1) begin
                checks++;
                if (row_data[RW-1:0] !== rom_word(10'(exp_a[i]))) begin
                    errors++;
                    $display("FAIL boundary_data line%0d: got %h exp %h",
                             lines[i], row_data[RW-1:0], rom_word(10'(exp_a[i])));
                end
            end
        end
        cfg(4'b0001, 10'd470, 10'd300, 10'd300, 10'd300,
            10'h040, 10'h100, 10'h200, 10'h300);
        start_line(10'd5);
        wait_done(1, at);
        swap_now();
        checks++;
        if (row_valid !== 4'b0000) begin
            errors++;
            $display("FAIL boundary_wrap: got %b exp 0000", row_valid);
        end
    endtask

    task automatic test_all_hit();
        logic [9:0] exp_a [4];
        int at;
        exp_a[0] = 10'h045;
        exp_a[1] = 10'h10F;
        exp_a[2] = 10'h200;
        exp_a[3] = 10'h309;
        cfg(4'b1111, 10'd100, 10'd90, 10'd105, 10'd96,
            10'h040, 10'h100, 10'h200, 10'h300);
        start_line(10'd105);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (rom_rd_en !== 1'b1 || rom_addr !== exp_a[c-1]) begin
                errors++;
                $display("FAIL all_issue c%0d: rd %b addr %h exp rd 1 addr %h",
                         c, rom_rd_en, rom_addr, exp_a[c-1]);
            end
            step(1);
        end
        wait_done(5, at);
        checks++;
        if (at !== 7) begin
            errors++;
            $display("FAIL all_done_cycle: got %0d exp 7", at);
        end
        swap_now();
        checks++;
        if (row_valid !== 4'b1111) begin
            errors++;
            $display("FAIL all_valid: got %b exp 1111", row_valid);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (row_data[i*RW +: RW] !== rom_word(exp_a[i])) begin
                errors++;
                $display("FAIL all_slot%0d: got %h exp %h",
                         i, row_data[i*RW +: RW], rom_word(exp_a[i]));
            end
        end
    endtask

    task automatic test_overrun_late();
        cfg(4'b0001, 10'd100, 10'd300, 10'd300, 10'd300,
            10'h040, 10'h100, 10'h200, 10'h300);
        start_line(10'd105);
        step(2);
        next_line  = 10'd99;
        line_start = 1'b1;
        step(1);
        line_start = 1'b0;
        checks++;
        if (err_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: got %b exp 1", err_overrun);
        end
        swap = 1'b1;
        step(1);
        swap = 1'b0;
        checks++;
        if ({err_late, row_valid, busy} !== {1'b1, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL late_swap: late/valid/busy got %b exp 1_0000_1",
                     {err_late, row_valid, busy});
        end
        step(2);
        checks++;
        if ({fetch_done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL overrun_done_c7: done/busy got %b exp 10", {fetch_done, busy});
        end
        swap_now();
        checks++;
        if (row_valid !== 4'b0001 || row_data[RW-1:0] !== rom_word(10'h045)) begin
            errors++;
            $display("FAIL overrun_snapshot: valid %b data %h exp 0001 %h",
                     row_valid, row_data[RW-1:0], rom_word(10'h045));
        end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        checks++;
        if ({err_overrun, err_late} !== 2'b00) begin
            errors++;
            $display("FAIL err_clr: got %b exp 00", {err_overrun, err_late});
        end
    endtask

    task automatic test_reset_mid();
        int at;
        cfg(4'b1111, 10'd100, 10'd90, 10'd105, 10'd96,
            10'h040, 10'h100, 10'h200, 10'h300);
        start_line(10'd105);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if ({busy, rom_rd_en, fetch_done, row_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid: busy/rd/done/valid got %b exp 0000000",
                     {busy, rom_rd_en, fetch_done, row_valid});
        end
        cfg(4'b0001, 10'd100, 10'd90, 10'd105, 10'd96,
            10'h040, 10'h100, 10'h200, 10'h300);
        start_line(10'd105);
        wait_done(1, at);
        checks++;
        if (at !== 7) begin
            errors++;
            $display("FAIL reset_mid_done_cycle: got %0d exp 7", at);
        end
        swap_now();
        checks++;
        if (row_valid !== 4'b0001 || row_data[RW-1:0] !== rom_word(10'h045)) begin
            errors++;
            $display("FAIL reset_mid_stale: valid %b data %h exp 0001 %h",
                     row_valid, row_data[RW-1:0], rom_word(10'h045));
        end
    endtask

    task automatic test_back_to_back();
        int at;
        cfg(4'b1111, 10'd100, 10'd90, 10'd105, 10'd96,
            10'h040, 10'h100, 10'h200, 10'h300);
        start_line(10'd105);
        wait_done(1, at);
        step(1);
        cfg(4'b0001, 10'd100, 10'd300, 10'd300, 10'd300,
            10'h040, 10'h100, 10'h200, 10'h300);
        next_line  = 10'd100;
        swap       = 1'b1;
        line_start = 1'b1;
        step(1);
        swap       = 1'b0;
        line_start = 1'b0;
        checks++;
        if (row_valid !== 4'b1111 || busy !== 1'b1) begin
            errors++;
            $display("FAIL swap_start_front: valid %b busy %b exp 1111 1", row_valid, busy);
        end
        checks++;
        if (row_data[RW +: RW] !== rom_word(10'h10F)) begin
            errors++;
            $display("FAIL swap_start_slot1: got %h exp %h", row_data[RW +: RW], rom_word(10'h10F));
        end
        wait_done(1, at);
        checks++;
        if (at !== 7) begin
            errors++;
            $display("FAIL swap_start_done_cycle: got %0d exp 7", at);
        end
        swap_now();
        checks++;
        if (row_valid !== 4'b0001 || row_data[RW-1:0] !== rom_word(10'h040)) begin
            errors++;
            $display("FAIL swap_start_new: valid %b data %h exp 0001 %h",
                     row_valid, row_data[RW-1:0], rom_word(10'h040));
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        line_start  = 1'b0;
        next_line   = '0;
        swap        = 1'b0;
        sprite_en   = '0;
        sprite_y    = '0;
        sprite_base = '0;
        err_clr     = 1'b0;
        test_reset();
        test_single_hit();
        test_boundaries();
        test_all_hit();
        test_overrun_late();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
